serial_parallel: RTL and testbench
==================================

// Module: serial_parallel
// PURPOSE
//  Input absorber of the SHA3 datapath, directly upstream of the Keccak core. Collects 64-bit message
//  words serially, applies SHA3 padding (domain byte + final 0x80) and presents one full rate block
//  per handshake to the core. This block mirrors the digest serializer downstream: the first message
//  byte is in in_data[63:56], and it lands in lane byte 0 (block[7:0]).
// PARAMETERS
//  RATE_LANES  17     64-bit lanes per rate block (17 = 1088 bits, SHA3-256)
//  DOMAIN      8'h06  domain-separation pad byte (8'h1F for SHAKE)
// PORTS
//  clk          in   1              rising-edge clock
//  reset        in   1              synchronous, active-high reset
//  in_valid     in   1              in_data/in_last/in_bytes valid
//  in_ready     out  1              word accepted when in_valid & in_ready
//  in_data      in   64             message word, first byte in [63:56]
//  in_last      in   1              final word of the message
//  in_bytes     in   4              valid bytes of the final word, 0..8; ignored unless in_last
//  block        out  64*RATE_LANES  rate block; lane k = block[64k+63:64k], byte j at [8j+7:8j]
//  block_valid  out  1              block is stable and offered to the core
//  block_ready  in   1              core accepts the block when block_valid & block_ready
//  block_last   out  1              block is the final (padded) block of the message
// BEHAVIOUR
//  - Reset: in_ready=0 for the reset cycle, then 1. block, block_valid and block_last are all 0.
//    The word counter is 0 and the FSM is in FILL. Reset mid-operation discards the partial block.
//  - Word mapping: accepted byte i of in_data (i=0 is [63:56]) goes to lane[wcnt] byte i.
//  - FSM states FILL, EMIT, PADBLK. in_ready=1 only in FILL.
//  - FILL: each accepted word is stored at lane wcnt, then wcnt increments.
//    Non-last word with wcnt==RATE_LANES-1 -> EMIT with block_last=0.
//    in_last -> EMIT with block_last=1.
//  - Last-word padding, with n = clamp(in_bytes,8) and p = 8*wcnt + n:
//    Bytes n..7 of the word are forced to 0, then byte p ^= DOMAIN.
//    Lanes above wcnt are zeroed. Byte 8*RATE_LANES-1 ^= 0x80, so DOMAIN^0x80 (0x86) if p coincides.
//  - Exact-fill case: n==8 and wcnt==RATE_LANES-1, so p is outside the block.
//    That block is emitted with block_last=0 and flag pad_pending is set.
//  - EMIT: block_valid=1 and the block is held stable until block_ready.
//    On the handshake, if pad_pending -> PADBLK. Otherwise clear the buffer, wcnt=0, and go to FILL.
//  - PADBLK: block = all zero, except byte0=DOMAIN and byte 8*RATE_LANES-1=0x80.
//    block_valid=1 and block_last=1; on the handshake -> FILL, clear pad_pending.
//  - Latency: block_valid rises on the cycle after the completing word's handshake.
//    in_ready rises the cycle after the block handshake. There is no overlap between a held block and
//    new input (single buffer).
//  - A new message starts in FILL at wcnt=0 and needs no extra start signal.
//  - in_valid while in_ready=0: the word is not consumed and the source must hold it.
// CONFIGURATION
//  SP_LEN_COUNT_EN defined:
//    - Adds output msg_len [63:0], the count of message bytes absorbed (n for the last word, 8 otherwise).
//    - Reset value 0. It is cleared by the first accepted word of a new message, which then loads that
//      word's count.
//    - msg_len holds its value after the last word until the next message starts. It wraps modulo 2^64.
//  SP_LEN_COUNT_EN not defined: the port and the counter are absent, and all other behaviour is
//  identical.
// TESTING
//  1. Empty message, in_last=1, in_bytes=0, block_ready=1:
//     -> one block with lane0=64'h06, lane16=64'h8000_0000_0000_0000, all other lanes 0, block_last=1.
//  2. "abc" (in_data=64'h6162_6300_0000_0000, in_bytes=3, in_last=1):
//     -> lane0=64'h0000_0000_0663_6261, lane16[63:56]=8'h80, block_last=1.
//  3. 135 bytes (16 full words, then in_bytes=7 on the last word):
//     -> one block with lane16[63:56]=8'h86, block_last=1.
//  4. 136 bytes (17 full words):
//     -> data block with block_last=0.
//     -> then a PADBLK with lane0=64'h06, lane16[63:56]=8'h80, block_last=1.
//     -> in_ready stays 0 across both blocks.
//  5. Backpressure: block_ready=0 for 5 cycles after block_valid.
//     -> block is bit-stable, in_ready=0, and in_data is not consumed.
//     -> one handshake on the cycle block_ready rises, then in_ready=1 on the following cycle.
//  6. Reset asserted after 9 words of a block:
//     -> next cycle block_valid=0 and wcnt=0.
//     -> a following empty message yields exactly the block of test 1.

Source files
------------

// File: rtl/serial_parallel.sv
// SHA3 input absorber: packs 64-bit message words into a rate block, applies domain/0x80 padding.
// Optional build macro SP_LEN_COUNT_EN adds the msg_len byte counter output.
module serial_parallel #(
    parameter int          RATE_LANES = 17,
    parameter logic [7:0]  DOMAIN     = 8'h06
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [63:0]               in_data,
    input  logic                      in_last,
    input  logic [3:0]                in_bytes,
    output logic [64*RATE_LANES-1:0]  block,
    output logic                      block_valid,
    input  logic                      block_ready,
    output logic                      block_last
`ifdef SP_LEN_COUNT_EN
    ,
    output logic [63:0]               msg_len
`endif
);

    localparam int NB  = 8 * RATE_LANES;
    localparam int WCW = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;

    typedef enum logic [1:0] {FILL, EMIT, PADBLK} state_t;

    state_t           state_reg;
    logic [WCW-1:0]   wcnt_reg;
    logic             in_ready_reg;
    logic             block_valid_reg;
    logic             block_last_reg;
    logic             pad_pending_reg;
    logic [7:0]       buf_reg [NB];

    logic [7:0]       fill_byte [NB];
    logic [7:0]       pad_byte  [NB];
    logic [3:0]       n_bytes;
    logic             accept;
    logic             lane_full;
    logic             exact_fill;
    logic             do_pad;
    logic [31:0]      pad_pos;

    assign n_bytes    = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    assign accept     = in_valid & in_ready_reg;
    assign lane_full  = (wcnt_reg == WCW'(RATE_LANES - 1));
    assign exact_fill = (n_bytes == 4'd8) && lane_full;
    assign do_pad     = in_last && !exact_fill;
    assign pad_pos    = 32'(wcnt_reg) * 32'd8 + 32'(n_bytes);

    assign in_ready    = in_ready_reg;
    assign block_valid = block_valid_reg;
    assign block_last  = block_last_reg;

    // Per-byte view of the buffer after absorbing the word on the input port
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_byte
            localparam int         LANE    = gi / 8;
            localparam int         BI      = gi % 8;
            localparam logic [7:0] PAD_BEG = (gi == 0)      ? DOMAIN : 8'h00;
            localparam logic [7:0] PAD_END = (gi == NB - 1) ? 8'h80  : 8'h00;

            logic [7:0] in_byte;
            logic [7:0] base_byte;
            logic       keep_byte;

            assign in_byte   = in_data[63-8*BI -: 8];
            assign keep_byte = !in_last || (4'(BI) < n_bytes);

            always_comb begin
                base_byte = buf_reg[gi];
                if (wcnt_reg == WCW'(LANE))
                    base_byte = keep_byte ? in_byte : 8'h00;
                else if (in_last && (int'(wcnt_reg) < LANE))
                    base_byte = 8'h00;
            end

            assign fill_byte[gi] = base_byte
                                 ^ ((do_pad && (pad_pos == 32'(gi))) ? DOMAIN : 8'h00)
                                 ^ (do_pad ? PAD_END : 8'h00);
            assign pad_byte[gi]  = PAD_BEG ^ PAD_END;
            assign block[8*gi +: 8] = buf_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= FILL;
            wcnt_reg        <= '0;
            in_ready_reg    <= 1'b0;
            block_valid_reg <= 1'b0;
            block_last_reg  <= 1'b0;
            pad_pending_reg <= 1'b0;
            for (int j = 0; j < NB; j++) buf_reg[j] <= 8'h00;
        end else begin
            case (state_reg)
                FILL: begin
                    in_ready_reg <= 1'b1;
                    if (accept) begin
                        for (int j = 0; j < NB; j++) buf_reg[j] <= fill_byte[j];
                        if (in_last || lane_full) begin
                            state_reg       <= EMIT;
                            in_ready_reg    <= 1'b0;
                            block_valid_reg <= 1'b1;
                            block_last_reg  <= do_pad;
                            pad_pending_reg <= in_last && exact_fill;
                        end else begin
                            wcnt_reg <= wcnt_reg + WCW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (block_ready) begin
                        if (pad_pending_reg) begin
                            // Message ended exactly on a block boundary: padding gets its own block
                            for (int j = 0; j < NB; j++) buf_reg[j] <= pad_byte[j];
                            state_reg      <= PADBLK;
                            block_last_reg <= 1'b1;
                        end else begin
                            for (int j = 0; j < NB; j++) buf_reg[j] <= 8'h00;
                            state_reg       <= FILL;
                            wcnt_reg        <= '0;
                            in_ready_reg    <= 1'b1;
                            block_valid_reg <= 1'b0;
                            block_last_reg  <= 1'b0;
                        end
                    end
                end
                PADBLK: begin
                    if (block_ready) begin
                        for (int j = 0; j < NB; j++) buf_reg[j] <= 8'h00;
                        state_reg       <= FILL;
                        wcnt_reg        <= '0;
                        in_ready_reg    <= 1'b1;
                        block_valid_reg <= 1'b0;
                        block_last_reg  <= 1'b0;
                        pad_pending_reg <= 1'b0;
                    end
                end
                default: state_reg <= FILL;
            endcase
        end
    end

`ifdef SP_LEN_COUNT_EN
    logic [63:0] msg_len_reg;
    logic        msg_start_reg;
    logic [63:0] word_count;

    assign word_count = in_last ? 64'(n_bytes) : 64'd8;
    assign msg_len    = msg_len_reg;

    // The first word of a message restarts the count instead of adding to it
    always_ff @(posedge clk) begin
        if (reset) begin
            msg_len_reg   <= 64'd0;
            msg_start_reg <= 1'b1;
        end else if (accept) begin
            msg_len_reg   <= msg_start_reg ? word_count : msg_len_reg + word_count;
            msg_start_reg <= in_last;
        end
    end
`endif

endmodule

// File: tb/tb_serial_parallel.sv
// Directed bench for serial_parallel: single-word vector table plus multi-cycle block sequences.
module tb_serial_parallel;

    localparam int RL = 17;
    localparam int BW = 64 * RL;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic          in_last;
    logic [3:0]    in_bytes;
    logic [BW-1:0] block;
    logic          block_valid;
    logic          block_ready;
    logic          block_last;
`ifdef SP_LEN_COUNT_EN
    logic [63:0]   msg_len;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    logic [BW-1:0] exp_blk;

    always #5 clk = ~clk;

    serial_parallel #(.RATE_LANES(RL), .DOMAIN(8'h06)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_bytes    (in_bytes),
        .block       (block),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_last  (block_last)
`ifdef SP_LEN_COUNT_EN
        ,
        .msg_len     (msg_len)
`endif
    );

    typedef struct {
        logic [63:0] data;
        logic [3:0]  nb;
        logic [63:0] l0;
        logic [63:0] l1;
        logic [63:0] ml;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_blk(input string name, input logic [BW-1:0] exp);
        int first;
        first = -1;
        n_cmp++;
        if (block !== exp) begin
            n_fail++;
            for (int k = 0; k < RL; k++)
                if (first < 0 && block[64*k +: 64] !== exp[64*k +: 64]) first = k;
            if (first < 0) first = 0;
            $display("FAIL %s: lane %0d got %h expected %h", name, first,
                     block[64*first +: 64], exp[64*first +: 64]);
        end
    endtask

    function automatic logic [BW-1:0] std_blk(input logic [63:0] l0, input logic [63:0] l1);
        logic [BW-1:0] b;
        b = '0;
        b[63:0]       = l0;
        b[127:64]     = l1;
        b[BW-1 -: 64] = 64'h8000_0000_0000_0000;
        return b;
    endfunction

    // Caller is at a negedge; returns at the negedge after the word was accepted
    task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
        int cyc;
        cyc      = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        while (in_ready !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (in_ready !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_word timeout: in_ready %b expected 1", in_ready);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take_block();
        block_ready = 1'b1;
        @(negedge clk);
        block_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'd0,  64'h0000_0000_0000_0006, 64'h0, 64'd0};
        vecs[1] = '{64'h6162_6300_0000_0000, 4'd3,  64'h0000_0000_0663_6261, 64'h0, 64'd3};
        vecs[2] = '{64'h0102_0304_0506_0708, 4'd8,  64'h0807_0605_0403_0201, 64'h6, 64'd8};
        vecs[3] = '{64'h0102_0304_0506_0708, 4'd12, 64'h0807_0605_0403_0201, 64'h6, 64'd8};
        vecs[4] = '{64'hAABB_CCDD_EEFF_0011, 4'd1,  64'h0000_0000_0000_06AA, 64'h0, 64'd1};
        vecs[5] = '{64'h1122_3344_5566_7788, 4'd7,  64'h0677_6655_4433_2211, 64'h0, 64'd7};

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = '0; block_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset in_ready", in_ready, 1'b0);
        chk("reset block_valid", block_valid, 1'b0);
        chk("reset block_last", block_last, 1'b0);
        chk_blk("reset block", '0);
`ifdef SP_LEN_COUNT_EN
        chk("reset msg_len", msg_len, 64'd0);
`endif
        reset = 1'b0;

        // Single-word messages from the table
        for (int i = 0; i < 6; i++) begin
            send_word(vecs[i].data, 1'b1, vecs[i].nb);
            chk($sformatf("v%0d valid latency", i), block_valid, 1'b1);
            chk($sformatf("v%0d last", i), block_last, 1'b1);
            chk($sformatf("v%0d in_ready held", i), in_ready, 1'b0);
            chk_blk($sformatf("v%0d block", i), std_blk(vecs[i].l0, vecs[i].l1));
`ifdef SP_LEN_COUNT_EN
            chk($sformatf("v%0d msg_len", i), msg_len, vecs[i].ml);
`endif
            take_block();
            chk($sformatf("v%0d valid after hs", i), block_valid, 1'b0);
            chk($sformatf("v%0d in_ready after hs", i), in_ready, 1'b1);
        end

        // 135 bytes: padding collides with the final byte -> 0x86
        for (int k = 0; k < 16; k++) send_word({8{8'(k + 1)}}, 1'b0, 4'd8);
        send_word(64'hA1A2_A3A4_A5A6_A7A8, 1'b1, 4'd7);
        exp_blk = '0;
        for (int k = 0; k < 16; k++) exp_blk[64*k +: 64] = {8{8'(k + 1)}};
        exp_blk[BW-1 -: 64] = 64'h86A7_A6A5_A4A3_A2A1;
        chk("b135 valid", block_valid, 1'b1);
        chk("b135 last", block_last, 1'b1);
        chk_blk("b135 block", exp_blk);
`ifdef SP_LEN_COUNT_EN
        chk("b135 msg_len", msg_len, 64'd135);
`endif
        take_block();
        chk("b135 valid after hs", block_valid, 1'b0);

        // 136 bytes: exact fill, then a separate padding block
        for (int k = 0; k < 17; k++) send_word({8{8'(k + 1)}}, (k == 16), 4'd8);
        exp_blk = '0;
        for (int k = 0; k < 17; k++) exp_blk[64*k +: 64] = {8{8'(k + 1)}};
        chk("b136 data valid", block_valid, 1'b1);
        chk("b136 data last", block_last, 1'b0);
        chk_blk("b136 data block", exp_blk);
        @(negedge clk);
        @(negedge clk);
        chk("b136 data in_ready", in_ready, 1'b0);
        take_block();
        chk("b136 pad valid", block_valid, 1'b1);
        chk("b136 pad last", block_last, 1'b1);
        chk("b136 pad in_ready", in_ready, 1'b0);
        chk_blk("b136 pad block", std_blk(64'h6, 64'h0));
`ifdef SP_LEN_COUNT_EN
        chk("b136 msg_len", msg_len, 64'd136);
`endif
        take_block();
        chk("b136 valid after pad hs", block_valid, 1'b0);
        chk("b136 in_ready after pad hs", in_ready, 1'b1);

        // 138 bytes: full non-last block, then a short final block (no pad block)
        for (int k = 0; k < 17; k++) send_word({8{8'(k + 1)}}, 1'b0, 4'd8);
        chk("b138 first last", block_last, 1'b0);
        chk_blk("b138 first block", exp_blk);
        take_block();
        chk("b138 no pad block", block_valid, 1'b0);
        send_word(64'hC1C2_C3C4_C5C6_C7C8, 1'b1, 4'd2);
        chk("b138 second last", block_last, 1'b1);
        chk_blk("b138 second block", std_blk(64'h0000_0000_0006_C2C1, 64'h0));
`ifdef SP_LEN_COUNT_EN
        chk("b138 msg_len", msg_len, 64'd138);
`endif
        take_block();

        // Backpressure: block held for 5 cycles while the next word waits
        send_word(64'h6162_6300_0000_0000, 1'b1, 4'd3);
        in_valid = 1'b1; in_data = 64'h7700_0000_0000_0000; in_last = 1'b1; in_bytes = 4'd1;
        for (int c = 0; c < 5; c++) begin
            chk_blk($sformatf("bp hold block c%0d", c), std_blk(64'h0000_0000_0663_6261, 64'h0));
            chk($sformatf("bp hold in_ready c%0d", c), in_ready, 1'b0);
            chk($sformatf("bp hold valid c%0d", c), block_valid, 1'b1);
            @(negedge clk);
        end
        take_block();
        chk("bp valid after hs", block_valid, 1'b0);
        chk("bp in_ready after hs", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("bp next valid", block_valid, 1'b1);
        chk_blk("bp next block", std_blk(64'h0000_0000_0000_0677, 64'h0));
`ifdef SP_LEN_COUNT_EN
        chk("bp msg_len", msg_len, 64'd1);
`endif
        take_block();

        // Reset in the middle of a block discards it
        for (int k = 0; k < 9; k++) send_word({8{8'(k + 1)}}, 1'b0, 4'd8);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid reset valid", block_valid, 1'b0);
        chk("mid reset in_ready", in_ready, 1'b0);
`ifdef SP_LEN_COUNT_EN
        chk("mid reset msg_len", msg_len, 64'd0);
`endif
        send_word(64'h0, 1'b1, 4'd0);
        chk("post reset last", block_last, 1'b1);
        chk_blk("post reset block", std_blk(64'h6, 64'h0));
        take_block();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
